// File: rtl/net_tx_packet_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : net_arb_pkg
// Brief    : Shared types and sizing helpers for the TX packet arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package net_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int max_beats(input int len_bytes, input int bus_width);
    return ceil_div(len_bytes, bus_width / 8);
  endfunction

endpackage
`default_nettype wire

// File: rtl/net_tx_packet_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : net_tx_packet_arbiter_if
// Brief    : Flattened multi-source ingress and single egress AXI-Stream bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface net_tx_packet_arbiter_if #(
  parameter int NUM_SOURCES     = 2,
  parameter int AXIS_BUS_WIDTH  = 64,
  parameter int AXIS_ID_WIDTH   = 3,
  parameter int AXIS_DEST_WIDTH = 1
);
  logic [NUM_SOURCES*AXIS_BUS_WIDTH-1:0]     axis_in_tdata;
  logic [NUM_SOURCES*AXIS_ID_WIDTH-1:0]      axis_in_tid;
  logic [NUM_SOURCES*AXIS_DEST_WIDTH-1:0]    axis_in_tdest;
  logic [NUM_SOURCES*AXIS_BUS_WIDTH/8-1:0]   axis_in_tkeep;
  logic [NUM_SOURCES-1:0]                    axis_in_tlast;
  logic [NUM_SOURCES-1:0]                    axis_in_tvalid;
  logic [NUM_SOURCES-1:0]                    axis_in_tready;

  logic [AXIS_BUS_WIDTH-1:0]                 axis_out_tdata;
  logic [AXIS_ID_WIDTH-1:0]                  axis_out_tid;
  logic [AXIS_DEST_WIDTH-1:0]                axis_out_tdest;
  logic [AXIS_BUS_WIDTH/8-1:0]               axis_out_tkeep;
  logic                                      axis_out_tlast;
  logic                                      axis_out_tvalid;
  logic                                      axis_out_tready;

  // master: the requesters plus the egress consumer; slave: the arbiter
  modport master (
    output axis_in_tdata, axis_in_tid, axis_in_tdest, axis_in_tkeep,
           axis_in_tlast, axis_in_tvalid, axis_out_tready,
    input  axis_in_tready, axis_out_tdata, axis_out_tid, axis_out_tdest,
           axis_out_tkeep, axis_out_tlast, axis_out_tvalid
  );

  modport slave (
    input  axis_in_tdata, axis_in_tid, axis_in_tdest, axis_in_tkeep,
           axis_in_tlast, axis_in_tvalid, axis_out_tready,
    output axis_in_tready, axis_out_tdata, axis_out_tid, axis_out_tdest,
           axis_out_tkeep, axis_out_tlast, axis_out_tvalid
  );
endinterface
`default_nettype wire

// File: rtl/net_tx_packet_arbiter_rr_priority_select.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_select
// Brief    : Combinational round-robin picker: first request at/after pointer.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_select #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  wire logic [N-1:0]  i_req,
  input  wire logic [IW-1:0] i_ptr,
  output logic      [N-1:0]  o_grant,
  output logic      [IW-1:0] o_idx,
  output logic               o_valid
);

  logic [IW-1:0] w_k;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_k     = '0;
    for (int off = 0; off < N; off++) begin
      w_k = IW'((int'(i_ptr) + off) % N);
      if (!o_valid && i_req[w_k]) begin
        o_valid      = 1'b1;
        o_idx        = w_k;
        o_grant[w_k] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/net_tx_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : net_tx_packet_arbiter
// Brief    : Packet-granular round-robin arbiter with max-length truncation.
// Revision : 1.0 - initial release
// ============================================================================
module net_tx_packet_arbiter
  import net_arb_pkg::*;
#(
  parameter int NUM_SOURCES       = 2,
  parameter int AXIS_BUS_WIDTH    = 64,
  parameter int AXIS_ID_WIDTH     = 3,
  parameter int AXIS_DEST_WIDTH   = 1,
  parameter int MAX_PACKET_LENGTH = 1522
) (
  input  wire logic                   axis_aclk,
  input  wire logic                   axis_aresetn,
  net_tx_packet_arbiter_if.slave      bus,
  input  wire logic [NUM_SOURCES-1:0] src_enable,
  output logic      [NUM_SOURCES-1:0] truncated_pulse,
  output logic      [NUM_SOURCES-1:0] grant_onehot
);

  localparam int MAX_BEATS = max_beats(MAX_PACKET_LENGTH, AXIS_BUS_WIDTH);
  localparam int BCW       = $clog2(MAX_BEATS + 1);
  localparam int IW        = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam int KW        = AXIS_BUS_WIDTH / 8;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BEATS - 1);

  arb_state_t             r_state;
  logic [NUM_SOURCES-1:0] r_grant;
  logic [IW-1:0]          r_idx;
  logic [IW-1:0]          r_ptr;
  logic [BCW-1:0]         r_beat_cnt;
  logic [NUM_SOURCES-1:0] r_trunc;

  logic [NUM_SOURCES-1:0] w_pick_grant;
  logic [IW-1:0]          w_pick_idx;
  logic                   w_pick_valid;

  rr_priority_select #(
    .N  (NUM_SOURCES),
    .IW (IW)
  ) u_rr_priority_select (
    .i_req   (bus.axis_in_tvalid & src_enable),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  logic w_g_tvalid;
  logic w_g_tlast;
  logic w_at_max;
  logic w_out_hs;
  logic [IW-1:0] w_ptr_next;

  assign w_g_tvalid = bus.axis_in_tvalid[r_idx];
  assign w_g_tlast  = bus.axis_in_tlast[r_idx];
  assign w_at_max   = (r_beat_cnt == LAST_BEAT);
  assign w_out_hs   = (r_state == PASS) && w_g_tvalid && bus.axis_out_tready;
  assign w_ptr_next = (r_idx == IW'(NUM_SOURCES - 1)) ? '0 : r_idx + 1'b1;

  logic [NUM_SOURCES-1:0]     w_in_tready;
  logic [AXIS_BUS_WIDTH-1:0]  w_tdata;
  logic [AXIS_ID_WIDTH-1:0]   w_tid;
  logic [AXIS_DEST_WIDTH-1:0] w_tdest;
  logic [KW-1:0]              w_tkeep;
  logic                       w_tlast;
  logic                       w_tvalid;

  // Zero-latency pass-through of the granted source; payload is zero in IDLE.
  always_comb begin
    w_in_tready = '0;
    w_tdata     = '0;
    w_tid       = '0;
    w_tdest     = '0;
    w_tkeep     = '0;
    w_tlast     = 1'b0;
    w_tvalid    = 1'b0;
    if (r_state != IDLE) begin
      w_tdata = bus.axis_in_tdata[r_idx*AXIS_BUS_WIDTH +: AXIS_BUS_WIDTH];
      w_tid   = bus.axis_in_tid[r_idx*AXIS_ID_WIDTH +: AXIS_ID_WIDTH];
      w_tdest = bus.axis_in_tdest[r_idx*AXIS_DEST_WIDTH +: AXIS_DEST_WIDTH];
      w_tkeep = bus.axis_in_tkeep[r_idx*KW +: KW];
    end
    if (r_state == PASS) begin
      w_tvalid           = w_g_tvalid;
      w_tlast            = w_g_tlast | w_at_max;
      w_in_tready[r_idx] = bus.axis_out_tready;
    end else if (r_state == DRAIN) begin
      w_in_tready[r_idx] = 1'b1;
    end
  end

  assign bus.axis_in_tready  = w_in_tready;
  assign bus.axis_out_tdata  = w_tdata;
  assign bus.axis_out_tid    = w_tid;
  assign bus.axis_out_tdest  = w_tdest;
  assign bus.axis_out_tkeep  = w_tkeep;
  assign bus.axis_out_tlast  = w_tlast;
  assign bus.axis_out_tvalid = w_tvalid;

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_idx      <= '0;
      r_ptr      <= '0;
      r_beat_cnt <= '0;
      r_trunc    <= '0;
    end else begin
      r_trunc <= '0;
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_grant <= w_pick_grant;
            r_idx   <= w_pick_idx;
            r_state <= PASS;
          end
        end
        PASS: begin
          if (w_out_hs) begin
            // A natural tlast wins over the length limit on the same beat.
            if (w_g_tlast) begin
              r_beat_cnt <= '0;
              r_ptr      <= w_ptr_next;
              r_grant    <= '0;
              r_state    <= IDLE;
            end else if (w_at_max) begin
              r_beat_cnt <= '0;
              r_trunc    <= r_grant;
              r_state    <= DRAIN;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (w_g_tvalid && w_g_tlast) begin
            r_ptr   <= w_ptr_next;
            r_grant <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant_onehot    = r_grant;
  assign truncated_pulse = r_trunc;

endmodule
`default_nettype wire

// File: tb/tb_net_tx_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_net_tx_packet_arbiter
// Brief    : Randomized bench with a packet-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_net_tx_packet_arbiter;

  localparam int NS   = 2;
  localparam int W    = 64;
  localparam int IDW  = 3;
  localparam int DW   = 1;
  localparam int MPL  = 64;
  localparam int MAXB = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NS-1:0] en;
  logic [NS-1:0] trunc;
  logic [NS-1:0] grant;
  logic          otr;

  always #5 clk = ~clk;

  net_tx_packet_arbiter_if #(
    .NUM_SOURCES(NS), .AXIS_BUS_WIDTH(W), .AXIS_ID_WIDTH(IDW), .AXIS_DEST_WIDTH(DW)
  ) bus ();

  net_tx_packet_arbiter #(
    .NUM_SOURCES(NS), .AXIS_BUS_WIDTH(W), .AXIS_ID_WIDTH(IDW),
    .AXIS_DEST_WIDTH(DW), .MAX_PACKET_LENGTH(MPL)
  ) dut (
    .axis_aclk       (clk),
    .axis_aresetn    (rst_n),
    .bus             (bus),
    .src_enable      (en),
    .truncated_pulse (trunc),
    .grant_onehot    (grant)
  );

  // Reference state: per-source beat queues {tlast, tdata} and packet owner.
  logic [W:0]    srcq [NS][$];
  logic [NS-1:0] pres;
  logic [NS-1:0] exp_trunc;
  logic [NS-1:0] force_en;
  bit            force_en_on;
  int            owner, beats, ptr;
  bit            drain;
  int            n_tests, n_fail;
  int            exp_beats, exp_trunc_cnt, obs_beats, obs_trunc;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic add_pkt(input int s, input int len);
    for (int b = 0; b < len; b++)
      srcq[s].push_back({(b == len - 1), $urandom, $urandom});
    exp_beats     += (len > MAXB) ? MAXB : len;
    exp_trunc_cnt += (len > MAXB) ? 1 : 0;
  endtask

  task automatic model_reset();
    owner = -1; beats = 0; ptr = 0; drain = 0;
    exp_trunc = '0; pres = '0;
    for (int i = 0; i < NS; i++) srcq[i].delete();
  endtask

  task automatic drive_inputs();
    logic [NS*W-1:0] d;
    logic [NS-1:0]   v, l;
    logic [W:0]      hd;
    for (int i = 0; i < NS; i++) begin
      if (!pres[i] && srcq[i].size() > 0 && $urandom_range(0, 9) < 8) pres[i] = 1'b1;
      hd = pres[i] ? srcq[i][0] : {1'b0, $urandom, $urandom};
      v[i] = pres[i];
      l[i] = pres[i] & hd[W];
      d[i*W +: W] = hd[W-1:0];
      en[i] = force_en_on ? force_en[i] : ($urandom_range(0, 3) != 0);
    end
    otr = ($urandom_range(0, 9) < 7);
    bus.axis_in_tvalid  = v;
    bus.axis_in_tlast   = l;
    bus.axis_in_tdata   = d;
    bus.axis_out_tready = otr;
  endtask

  // Compare DUT against the model for this cycle, then advance the model
  // across the coming clock edge.
  task automatic check_update();
    logic [NS-1:0] exp_rdy, exp_gnt, req;
    logic [W:0]    hd;
    logic          ev;
    bit            hs;
    exp_rdy = '0; exp_gnt = '0; ev = 1'b0; hd = '0;
    if (owner >= 0) begin
      exp_gnt[owner] = 1'b1;
      exp_rdy[owner] = drain ? 1'b1 : otr;
      ev = !drain && pres[owner];
      if (pres[owner]) hd = srcq[owner][0];
    end
    chk("grant", grant, exp_gnt);
    chk("in_tready", bus.axis_in_tready, exp_rdy);
    chk("out_tvalid", bus.axis_out_tvalid, ev);
    chk("trunc_pulse", trunc, exp_trunc);
    if (ev) begin
      chk("out_tdata", bus.axis_out_tdata, hd[W-1:0]);
      chk("out_tlast", bus.axis_out_tlast, hd[W] | (beats == MAXB - 1));
      chk("out_tid", bus.axis_out_tid, (owner == 0) ? 3'd0 : 3'd1);
      chk("out_tkeep", bus.axis_out_tkeep, (owner == 0) ? 8'hFF : 8'h0F);
    end
    if (bus.axis_out_tvalid && otr) obs_beats++;
    for (int i = 0; i < NS; i++) obs_trunc += int'(trunc[i]);

    exp_trunc = '0;
    req = pres & en;
    if (owner < 0) begin
      for (int k = 0; k < NS; k++)
        if (owner < 0 && req[(ptr + k) % NS]) owner = (ptr + k) % NS;
    end else begin
      hs = drain ? pres[owner] : (ev && otr);
      if (hs) begin
        hd = srcq[owner].pop_front();
        pres[owner] = 1'b0;
        if (hd[W]) begin
          ptr = (owner + 1) % NS; owner = -1; beats = 0; drain = 0;
        end else if (!drain) begin
          if (beats == MAXB - 1) begin
            drain = 1; exp_trunc[owner] = 1'b1; beats = 0;
          end else begin
            beats++;
          end
        end
      end
    end
  endtask

  task automatic cycle();
    drive_inputs();
    @(negedge clk);
    check_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    n_tests = 0; n_fail = 0;
    exp_beats = 0; exp_trunc_cnt = 0; obs_beats = 0; obs_trunc = 0;
    force_en_on = 0; force_en = '0;
    model_reset();
    bus.axis_in_tvalid  = '0;
    bus.axis_in_tlast   = '0;
    bus.axis_in_tdata   = '0;
    bus.axis_in_tid     = {3'd1, 3'd0};
    bus.axis_in_tdest   = 2'b10;
    bus.axis_in_tkeep   = {8'h0F, 8'hFF};
    bus.axis_out_tready = 1'b1;
    otr = 1'b1;
    en  = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_grant", grant, '0);
    chk("rst_tready", bus.axis_in_tready, '0);
    chk("rst_tvalid", bus.axis_out_tvalid, 1'b0);
    chk("rst_trunc", trunc, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed lengths first (exact, over-long), then random mix.
    add_pkt(0, 8);
    add_pkt(1, 12);
    add_pkt(0, 4);
    add_pkt(1, 6);
    for (int p = 0; p < 24; p++) add_pkt($urandom_range(0, 1), $urandom_range(1, 12));
    cyc = 0;
    while ((srcq[0].size() > 0 || srcq[1].size() > 0 || owner >= 0) && cyc < 20000) begin
      cycle();
      cyc++;
    end
    chk("random_done", (cyc < 20000), 1'b1);
    cycle();
    chk("beat_total", obs_beats, exp_beats);
    chk("trunc_total", obs_trunc, exp_trunc_cnt);

    // Reset in the middle of a packet.
    force_en_on = 1; force_en = 2'b01;
    add_pkt(0, 6);
    cyc = 0;
    while (!(owner == 0 && beats >= 2) && cyc < 200) begin
      cycle();
      cyc++;
    end
    chk("reach_mid_pkt", (cyc < 200), 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_tready", bus.axis_in_tready, '0);
    chk("midrst_tvalid", bus.axis_out_tvalid, 1'b0);
    chk("midrst_grant", grant, '0);
    model_reset();
    bus.axis_in_tvalid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Both valid, only source 1 enabled: source 1 must win despite ptr=0.
    add_pkt(0, 3);
    add_pkt(1, 3);
    pres = 2'b11;
    force_en = 2'b10;
    cycle();
    chk("first_grant", grant, 2'b10);
    force_en_on = 0;
    cyc = 0;
    while ((srcq[0].size() > 0 || srcq[1].size() > 0 || owner >= 0) && cyc < 500) begin
      cycle();
      cyc++;
    end
    chk("final_done", (cyc < 500), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
